// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter serialising per-core requests onto one single-ported memory.
// Optional macro ARB_LOCK_EN adds a per-core lock input that keeps the pointer on its owner.
module core_mem_arbiter #(
  parameter int CORES       = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CORES-1:0]         req,
  input  logic [CORES-1:0]         we,
  input  logic [CORES*ADDR_W-1:0]  addr,
  input  logic [CORES*DATA_W-1:0]  wdata,
`ifdef ARB_LOCK_EN
  input  logic [CORES-1:0]         lock,
`endif
  output logic [CORES-1:0]         gnt,
  output logic [CORES-1:0]         done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int PTR_W = $clog2(CORES);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [PTR_W:0]   CORES_V = (PTR_W + 1)'(CORES);
  localparam logic [CNT_W-1:0] LAT_V   = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [PTR_W-1:0]   ptr_r, ptr_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [CORES-1:0]   gnt_r, gnt_s, done_r, done_s;
  logic [DATA_W-1:0]  rdata_r, rdata_s, mem_wdata_r, mem_wdata_s;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;
  logic               busy_r, busy_s, mem_en_r, mem_en_s, mem_we_r, mem_we_s;
  logic               win_found_s;
  logic [PTR_W-1:0]   win_idx_s, cand_s;
`ifdef ARB_LOCK_EN
  logic               lock_held_r, lock_held_s;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W:0] nxt;
    nxt = {1'b0, p} + {{PTR_W{1'b0}}, 1'b1};
    if (nxt >= CORES_V) begin
      return {PTR_W{1'b0}};
    end else begin
      return nxt[PTR_W-1:0];
    end
  endfunction

  // Winner search: first requesting lane at or after ptr, wrapping modulo CORES.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    cand_s      = ptr_r;
    for (int k = 0; k < CORES; k++) begin
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
      cand_s = ptr_inc(cand_s);
    end
  end

  // Next-state and next-output logic for the IDLE -> ISSUE -> WAIT cycle.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    cnt_s       = cnt_r;
    gnt_s       = gnt_r;
    done_s      = {CORES{1'b0}};
    rdata_s     = rdata_r;
    mem_en_s    = 1'b0;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
`ifdef ARB_LOCK_EN
    lock_held_s = lock_held_r;
`endif
    case (state_r)
      IDLE: begin
        gnt_s = {CORES{1'b0}};
        if (win_found_s) begin
          state_s            = ISSUE;
          gnt_s[win_idx_s]   = 1'b1;
          mem_en_s           = 1'b1;
          mem_we_s           = we[win_idx_s];
          mem_addr_s         = addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
          mem_wdata_s        = wdata[int'(win_idx_s)*DATA_W +: DATA_W];
          cnt_s              = LAT_V;
`ifdef ARB_LOCK_EN
          // A locking winner keeps the pointer so its next request wins again.
          if (lock[win_idx_s]) begin
            ptr_s = win_idx_s;
          end else begin
            ptr_s = ptr_inc(win_idx_s);
          end
          lock_held_s = lock[win_idx_s];
`else
          ptr_s = ptr_inc(win_idx_s);
`endif
        end else begin
`ifdef ARB_LOCK_EN
          if (lock_held_r) begin
            ptr_s       = ptr_inc(ptr_r);
            lock_held_s = 1'b0;
          end else begin
            ptr_s = ptr_r;
          end
`else
          ptr_s = ptr_r;
`endif
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (cnt_r == CNT_ONE) begin
          state_s = IDLE;
          gnt_s   = {CORES{1'b0}};
          done_s  = gnt_r;
          cnt_s   = {CNT_W{1'b0}};
          if (!mem_we_r) begin
            rdata_s = mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = {CORES{1'b0}};
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= {PTR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      gnt_r       <= {CORES{1'b0}};
      done_r      <= {CORES{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
`ifdef ARB_LOCK_EN
      lock_held_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      cnt_r       <= cnt_s;
      gnt_r       <= gnt_s;
      done_r      <= done_s;
      rdata_r     <= rdata_s;
      busy_r      <= busy_s;
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
`ifdef ARB_LOCK_EN
      lock_held_r <= lock_held_s;
`endif
    end
  end

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-ported memory (data or instruction) among the cores of the multi-core `cpu`.
- Each core raises a request carrying address, write data and write enable. The arbiter serialises the requests onto the memory port and returns read data with a one-cycle completion pulse to the winning core.
- Sits between the per-core memory stages and the shared memory inside `cpu`. The `cores` parameter there drives CORES here.

Parameters:
- CORES, 4, number of requesting cores (≥2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  CORES  per-core request level.
- we  in  CORES  per-core write enable (1 = write).
- addr  in  CORES*ADDR_W  packed addresses; core i at bits [i*ADDR_W +: ADDR_W].
- wdata  in  CORES*DATA_W  packed write data, same packing as addr.
- gnt  out  CORES  one-hot; core owning the memory port.
- done  out  CORES  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  read data, broadcast to all cores, valid while done pulses.
- busy  out  1  high whenever state is not IDLE.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values: state=IDLE, ptr=0, gnt=0, done=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, latency counter=0.
- Reset asserted mid-transaction aborts it: no done pulse, and memory outputs are forced to reset values on the next edge.
- State machine: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE, at an edge with any req high:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, …, CORES-1, 0, … (wrap mod CORES).
  - Register gnt[winner]=1, mem_en=1, mem_we=we[winner], mem_addr/mem_wdata = winner payload.
  - Set ptr = (winner+1) mod CORES; load counter with MEM_LATENCY; go to ISSUE.
- IDLE with no req high: remain in IDLE, all strobes 0.
- ISSUE (exactly one cycle): mem_en high. Next edge: mem_en=0, go to WAIT. mem_addr, mem_wdata and mem_we are held until the transaction ends.
- WAIT: counter decrements each edge. When counter reaches 1 at an edge:
  - Capture rdata<=mem_rdata for reads; rdata holds its old value for writes.
  - done[winner]=1 for one cycle, gnt=0, state=IDLE.
- Latency: request sampled at edge E0 → mem_en high in cycle E0..E0+1 → done high in cycle E0+1+MEM_LATENCY .. E0+2+MEM_LATENCY. Peak throughput is one access per MEM_LATENCY+2 cycles.
- Payload sampling: only at the arbitration edge. A core must hold req and its payload stable until its done pulse.
- Req dropped before grant: no effect, no done. Req dropped after grant: the transaction still completes and done still pulses.
- Done cycle coincides with the IDLE cycle, so arbitration runs at the edge ending the done cycle.
  - A core that still holds req at that edge is treated as a new request.
  - ptr has already advanced past it, so other requesters win first.
- Out-of-range or X on unused lanes: ignored; only req-qualified lanes are read.
- Invariants: gnt and done are always one-hot or zero; gnt and done are never both nonzero in the same cycle.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - Adds input `lock` [CORES].
  - If lock[winner]=1 at the arbitration edge, ptr is left pointing at the winner instead of advancing. Its next request wins ahead of the others, which supports atomic read-modify-write.
  - Lock releases when the owner arbitrates with lock=0 or drops req for one IDLE edge.
- When undefined: port absent, pure round-robin as above.

Test Plan:
- Single read: reset 2 cycles; core 2 req, we=0, addr=0x10, mem returns 0xDEADBEEF (MEM_LATENCY=1).
  → gnt=0b0100 one edge later; mem_addr=0x10, mem_en one cycle; done=0b0100 and rdata=0xDEADBEEF exactly 3 cycles after the request edge.
- All-core contention: req=0b1111 held continuously, ptr=0.
  → grant order 0,1,2,3,0; each done one-hot; no gaps beyond MEM_LATENCY+2 cycles per access.
- Write: core 1 we=1, addr=0x8, wdata=0x12345678.
  → mem_we=1 with mem_en, mem_wdata=0x12345678; rdata unchanged; done=0b0010.
- Req withdrawn: core 3 req pulses for one cycle while core 0 is mid-transaction.
  → core 3 never granted, no done[3]; core 0 completes normally.
- Reset mid-op: assert reset during WAIT.
  → no done pulse; next edge shows gnt=0, mem_en=0, busy=0; following request from core 1 is granted first (ptr=0 scan).
- ARB_LOCK_EN: core 0 lock=1, req=0b0011 held.
  → core 0 granted twice consecutively before core 1; after lock=0, core 1 granted next.
